mips_mem_responder: RTL and testbench
=====================================

# mips_mem_responder

Word-addressed data-memory responder for the MIPS32 core's load/store path. It accepts one read or write request at a time over a valid/ready request channel, inserts a programmable number of wait states, performs the access, and returns data and status over a valid/ready response channel. It sits between the core's MEM stage (initiator) and a DEPTH-word storage array, and models a slow memory so that pipeline stalling can be exercised.

## Interface
- DEPTH, 1024, number of 32-bit words in the array
- AW, 10, index width; DEPTH ≤ 2^AW
- WAIT_CYCLES, 2, wait states between acceptance and access, legal range 0..15

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  initiator presents a request
- req_ready  out  1  responder can accept; high only in IDLE and rst low
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  word address; full 32 bits range-checked
- req_wdata  in  32  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  initiator takes response
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  address ≥ DEPTH
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. A request is accepted on a rising edge with req_valid && req_ready. At acceptance, the block latches req_we, req_addr and req_wdata, and sets err_q = (req_addr ≥ DEPTH).
  - If WAIT_CYCLES=0, the access is performed on the accepting edge and the FSM goes to RESP.
  - Otherwise the counter is loaded with WAIT_CYCLES−1 and the FSM goes to WAIT.
- WAIT: the counter decrements each edge. On the edge where the counter is 0, the access is performed and the FSM goes to RESP.
- Access, for in-range addresses:
  - Read: rsp_rdata ← mem[addr[AW-1:0]].
  - Write: mem[addr[AW-1:0]] ← wdata, and rsp_rdata ← 0.
- Access, for out-of-range addresses: no array write, rsp_rdata ← 0, rsp_err ← 1.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready. On that edge the FSM goes to IDLE and rsp_valid, rsp_err and rsp_rdata clear to 0.
- No request is accepted in the same cycle as a response handshake.
- req_valid asserted outside IDLE is ignored. The initiator must hold the request until it sees req_ready.
- Request inputs are sampled only at acceptance. Later changes to them have no effect on the transaction.
- The array is not cleared by reset. Contents persist across reset.

## Timing
- Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, counter=0, req_ready=0 while rst high.
- Latency: rsp_valid rises 1+WAIT_CYCLES cycles after the accepting edge. With the default setting (WAIT_CYCLES=2), this is 3 cycles.
- Minimum transaction period with rsp_ready tied high: 2+WAIT_CYCLES cycles.
- Read-after-write to the same address, in back-to-back transactions, returns the newly written data.
- Reset asserted in WAIT: the transaction is aborted, the pending write is NOT performed, and the FSM goes asynchronously to IDLE.
- Reset asserted in RESP: rsp_valid drops immediately, and an already-performed write remains in the array.
- Boundary addresses:
  - addr = DEPTH−1: valid access.
  - addr = DEPTH: error.
  - addr = 0xFFFFFFFF: error, with no aliasing onto addr[AW-1:0].

## Test plan
- WAIT_CYCLES=2, rsp_ready=1: write 0xDEADBEEF to addr 5, then read addr 5.
  - Required: rsp_valid 3 cycles after each accept, read rsp_rdata=0xDEADBEEF, rsp_err=0, write response rsp_rdata=0.
- WAIT_CYCLES=0: read addr 1023 preloaded with 0x12345678.
  - Required: rsp_valid the cycle after accept, rsp_rdata=0x12345678.
- Read addr 1024, then write 0xAA to addr 0x400.
  - Required: rsp_err=1 and rsp_rdata=0 for both responses, and mem[0] unchanged.
- Backpressure: rsp_ready=0 for 5 cycles in RESP while req_valid is held high with a new request.
  - Required: response stable, req_ready=0, new request accepted only in the cycle after the rsp handshake.
- Write 0x55 to addr 7 and assert rst during WAIT.
  - Required: rsp_valid never rises, busy=0 immediately, and a subsequent read of addr 7 returns the prior value.
- Random mix of 200 reads and writes with random rsp_ready against a reference array model.
  - Required: all responses match the model, and there is never more than one outstanding transaction.

Source files
------------

// File: rtl/mips_mem_responder.sv
// Word-addressed data-memory responder with programmable wait states.
// One request in flight; valid/ready request and response channels.
module mips_mem_responder #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned AW          = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           accept_c, access_c, rsp_done_c, req_oor_c;

   logic           we_q, err_q;
   logic [AW-1:0]  addr_q;
   logic [31:0]    wdata_q;

   logic           acc_we, acc_err;
   logic [AW-1:0]  acc_idx;
   logic [31:0]    acc_wdata;

   logic [31:0]    rdata_q;
   logic           rsp_err_q;

   logic [31:0]    mem [DEPTH];

   assign req_oor_c = (req_addr >= 32'(DEPTH));
   assign req_ready = (state == S_IDLE) && !rst;
   assign busy      = (state != S_IDLE);
   assign rsp_valid = (state == S_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = rsp_err_q;

   // Next-state and access strobe
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      access_c   = 1'b0;
      accept_c   = (state == S_IDLE) && req_valid && !rst;
      rsp_done_c = (state == S_RESP) && rsp_ready;
      unique case (state)
         S_IDLE: begin
            if (accept_c) begin
               if (WAIT_CYCLES == 0) begin
                  access_c  = 1'b1;
                  state_nxt = S_RESP;
               end else begin
                  cnt_nxt   = CW'(WAIT_CYCLES - 1);
                  state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt == '0) begin
               access_c  = 1'b1;
               state_nxt = S_RESP;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         S_RESP: begin
            if (rsp_done_c) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Zero-wait accesses use the live request; otherwise the latched copy
   always_comb begin
      if (state == S_IDLE) begin
         acc_we    = req_we;
         acc_err   = req_oor_c;
         acc_idx   = req_addr[AW-1:0];
         acc_wdata = req_wdata;
      end else begin
         acc_we    = we_q;
         acc_err   = err_q;
         acc_idx   = addr_q;
         acc_wdata = wdata_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept_c) begin
            we_q    <= req_we;
            err_q   <= req_oor_c;
            addr_q  <= req_addr[AW-1:0];
            wdata_q <= req_wdata;
         end
         if (access_c) begin
            rdata_q   <= (acc_we || acc_err) ? '0 : mem[acc_idx];
            rsp_err_q <= acc_err;
         end else if (rsp_done_c) begin
            rdata_q   <= '0;
            rsp_err_q <= 1'b0;
         end
      end
   end

   // Storage is deliberately not reset so contents survive rst
   always_ff @(posedge clk) begin
      if (access_c && acc_we && !acc_err) mem[acc_idx] <= acc_wdata;
   end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Testbench for mips_mem_responder: directed vectors plus a transaction-level
// reference model compared against the outputs every cycle.
module tb_mips_mem_responder;

   localparam int WC = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        rsp_ready = 1'b0;
   logic        req_ready, rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;

   logic        z_req_valid = 1'b0, z_req_we = 1'b0, z_rsp_ready = 1'b1;
   logic [31:0] z_req_addr = '0, z_req_wdata = '0;
   logic        z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
   logic [31:0] z_rsp_rdata;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   mips_mem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy)
   );

   mips_mem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
      .req_we(z_req_we), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
      .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
      .rsp_err(z_rsp_err), .busy(z_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timed_out(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // Reference: a request is answered WC edges after acceptance, then held until taken
   logic [31:0] mm [1024];
   logic        m_busy = 1'b0, m_resp = 1'b0, m_we = 1'b0, m_err = 1'b0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
   int          m_age = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0; m_resp <= 1'b0; m_err <= 1'b0; m_rdata <= '0; m_age <= 0;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy <= 1'b1; m_age <= 0;
            m_we <= req_we; m_addr <= req_addr; m_wdata <= req_wdata;
         end
      end else if (!m_resp) begin
         m_age <= m_age + 1;
         if (m_age + 1 == WC) begin
            m_resp <= 1'b1;
            if (m_addr > 32'd1023) begin
               m_err <= 1'b1; m_rdata <= '0;
            end else if (m_we) begin
               mm[m_addr[9:0]] <= m_wdata; m_rdata <= '0;
            end else begin
               m_rdata <= mm[m_addr[9:0]];
            end
         end
      end else if (rsp_ready) begin
         m_busy <= 1'b0; m_resp <= 1'b0; m_err <= 1'b0; m_rdata <= '0;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("m_req_ready", 32'(req_ready), 32'(!m_busy && !rst));
         chk("m_busy",      32'(busy),      32'(m_busy));
         chk("m_rsp_valid", 32'(rsp_valid), 32'(m_resp));
         chk("m_rsp_rdata", rsp_rdata,      m_rdata);
         chk("m_rsp_err",   32'(rsp_err),   32'(m_err));
      end
   end

   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid) timed_out("wait_rsp");
   endtask

   // Full transaction on the main instance; lat counts cycles from accept to rsp_valid
   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int stall, output logic [31:0] rdata, output logic err,
                      output int lat);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         timed_out("accept");
         req_valid = 1'b0; rdata = '0; err = 1'b0; lat = -1;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
      wait_rsp(lat);
      rdata = rsp_rdata;
      err   = rsp_err;
      repeat (stall) @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;

      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      chk("rst_busy",      32'(busy),      32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_rsp_rdata", rsp_rdata,      32'h0);
      chk("rst_rsp_err",   32'(rsp_err),   32'(0));
      #2 rst = 1'b0;
      chk_on = 1'b1;

      for (int i = 0; i < 32; i++) txn(1'b1, 32'(i), 32'hA000_0000 + 32'(i), 0, rd, er, lat);
      txn(1'b1, 32'd1023, 32'hA000_03FF, 0, rd, er, lat);

      txn(1'b1, 32'd5, 32'hDEAD_BEEF, 0, rd, er, lat);
      chk("wr5_lat", 32'(lat), 32'(3));
      chk("wr5_rdata", rd, 32'h0);
      chk("wr5_err", 32'(er), 32'(0));
      txn(1'b0, 32'd5, 32'h0, 1, rd, er, lat);
      chk("rd5_lat", 32'(lat), 32'(3));
      chk("rd5_rdata", rd, 32'hDEAD_BEEF);
      chk("rd5_err", 32'(er), 32'(0));

      txn(1'b0, 32'd1024, 32'h0, 0, rd, er, lat);
      chk("rd1024_err", 32'(er), 32'(1));
      chk("rd1024_rdata", rd, 32'h0);
      txn(1'b1, 32'h400, 32'hAA, 0, rd, er, lat);
      chk("wr400_err", 32'(er), 32'(1));
      chk("wr400_rdata", rd, 32'h0);
      txn(1'b0, 32'd0, 32'h0, 0, rd, er, lat);
      chk("rd0_unchanged", rd, 32'hA000_0000);
      txn(1'b1, 32'hFFFF_FFFF, 32'h1234, 0, rd, er, lat);
      chk("wrmax_err", 32'(er), 32'(1));
      txn(1'b0, 32'd1023, 32'h0, 0, rd, er, lat);
      chk("rd1023_no_alias", rd, 32'hA000_03FF);
      chk("rd1023_err", 32'(er), 32'(0));

      // Backpressure with a second request held on the channel
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd5;
      @(posedge clk);
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'd9; req_wdata = 32'h0BAD_F00D;
      wait_rsp(lat);
      for (int i = 0; i < 5; i++) begin
         chk("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
         chk("bp_req_ready", 32'(req_ready), 32'(0));
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk("bp_idle_after_rsp", 32'(busy), 32'(0));
      chk("bp_ready_after_rsp", 32'(req_ready), 32'(1));
      @(posedge clk);
      #1 chk("bp_accept_next", 32'(busy), 32'(1));
      req_valid = 1'b0;
      @(negedge clk);
      wait_rsp(lat);
      chk("bp_wr_rdata", rsp_rdata, 32'h0);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      txn(1'b0, 32'd9, 32'h0, 0, rd, er, lat);
      chk("bp_rd9", rd, 32'h0BAD_F00D);

      // Reset while waiting: pending write must be dropped
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd7; req_wdata = 32'h55;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rstwait_busy", 32'(busy), 32'(0));
      chk("rstwait_rsp_valid", 32'(rsp_valid), 32'(0));
      @(negedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rstwait_no_rsp", 32'(rsp_valid), 32'(0));
      end
      txn(1'b0, 32'd7, 32'h0, 0, rd, er, lat);
      chk("rstwait_rd7", rd, 32'hA000_0007);

      // Reset while responding: write already done must persist
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd9; req_wdata = 32'h99;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      wait_rsp(lat);
      #2 rst = 1'b1;
      #1 chk("rstresp_rsp_valid", 32'(rsp_valid), 32'(0));
      @(negedge clk);
      #2 rst = 1'b0;
      txn(1'b0, 32'd9, 32'h0, 0, rd, er, lat);
      chk("rstresp_rd9", rd, 32'h99);

      // Zero-wait instance
      @(negedge clk);
      z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'd1023; z_req_wdata = 32'h1234_5678;
      chk("z_ready", 32'(z_req_ready), 32'(1));
      @(posedge clk);
      @(negedge clk);
      z_req_valid = 1'b0;
      chk("z_wr_valid", 32'(z_rsp_valid), 32'(1));
      chk("z_wr_rdata", z_rsp_rdata, 32'h0);
      @(negedge clk);
      chk("z_wr_done", 32'(z_rsp_valid), 32'(0));
      z_req_valid = 1'b1; z_req_we = 1'b0;
      @(posedge clk);
      @(negedge clk);
      z_req_valid = 1'b0;
      chk("z_rd_valid", 32'(z_rsp_valid), 32'(1));
      chk("z_rd_rdata", z_rsp_rdata, 32'h1234_5678);
      chk("z_rd_err", 32'(z_rsp_err), 32'(0));

      // Random traffic, checked by the reference model
      for (int i = 0; i < 200; i++) begin
         logic [31:0] a;
         int unsigned r;
         r = $urandom_range(0, 15);
         if (r == 0)      a = 32'd1024;
         else if (r == 1) a = 32'hFFFF_FFFF;
         else if (r == 2) a = 32'd1023;
         else             a = 32'($urandom_range(0, 31));
         txn(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)), rd, er, lat);
         chk("rnd_lat", 32'(lat), 32'(WC + 1));
      end

      repeat (2) @(negedge clk);
      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
